// File: rtl/vend_controller.sv
// Vending-machine controller: coin credit, per-item price check, dispense
// handshake with timeout refund, and paced greedy change return.
module vend_controller #(
  parameter int unsigned NUM_ITEMS   = 8,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned PRICE_W     = 6,
  parameter int unsigned AUTO_CHANGE = 1,
  parameter int unsigned RET_GAP     = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_coin_valid,
  input  logic [1:0]                    i_coin_type,
  input  logic [3:0]                    i_key,
  input  logic                          i_key_ready,
  input  logic [NUM_ITEMS*PRICE_W-1:0]  i_item_prices,
  input  logic                          i_dispense_ack,
  output logic [CREDIT_W-1:0]           o_credit,
  output logic                          o_dispense_req,
  output logic [3:0]                    o_dispense_item,
  output logic                          o_ret_nickel,
  output logic                          o_ret_dime,
  output logic                          o_ret_quarter,
  output logic                          o_coin_reject,
  output logic                          o_sel_error,
  output logic                          o_fault,
  output logic                          o_busy
);

  localparam int unsigned SUM_W = ((CREDIT_W > 5) ? CREDIT_W : 5) + 1;
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(RET_GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_VEND, ST_CHANGE} state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [3:0]          r_item;
  logic [PRICE_W-1:0]  r_price;
  logic [TMR_W-1:0]    r_timer;
  logic [GAP_W-1:0]    r_gap;
  logic r_dispense_req, r_nickel, r_dime, r_quarter, r_reject, r_sel_err, r_fault, r_busy;

  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [3:0]          w_item_nxt;
  logic [PRICE_W-1:0]  w_price_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic w_nickel_nxt, w_dime_nxt, w_quarter_nxt, w_reject_nxt, w_sel_err_nxt, w_fault_nxt;
  logic w_take_chg;

  logic [PRICE_W-1:0]  w_price;
  logic                w_key_valid;
  logic [4:0]          w_coin_val;
  logic [SUM_W-1:0]    w_sum;
  logic                w_coin_ok;
  logic [SUM_W-1:0]    w_base;

  // Price lookup for the pressed key; keys outside the table are invalid
  always_comb begin
    w_price     = '0;
    w_key_valid = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_key == 4'(i)) begin
        w_price     = i_item_prices[i*PRICE_W +: PRICE_W];
        w_key_valid = 1'b1;
      end
    end
  end

  always_comb begin
    case (i_coin_type)
      2'd0:    w_coin_val = 5'd1;
      2'd1:    w_coin_val = 5'd2;
      2'd2:    w_coin_val = 5'd5;
      default: w_coin_val = 5'd20;
    endcase
  end

  // Coins are only taken in IDLE and only if the sum fits the credit register
  assign w_sum     = SUM_W'(r_credit) + SUM_W'(w_coin_val);
  assign w_coin_ok = i_coin_valid && (r_state == ST_IDLE) && ((w_sum >> CREDIT_W) == '0);
  assign w_base    = w_coin_ok ? w_sum : SUM_W'(r_credit);

  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_item_nxt    = r_item;
    w_price_nxt   = r_price;
    w_timer_nxt   = r_timer;
    w_gap_nxt     = r_gap;
    w_nickel_nxt  = 1'b0;
    w_dime_nxt    = 1'b0;
    w_quarter_nxt = 1'b0;
    w_sel_err_nxt = 1'b0;
    w_fault_nxt   = 1'b0;
    w_take_chg    = 1'b0;
    w_reject_nxt  = i_coin_valid && !w_coin_ok;

    case (r_state)
      ST_IDLE: begin
        w_credit_nxt = CREDIT_W'(w_base);
        if (i_key_ready) begin
          if (i_key == 4'hF) begin
            if (r_credit != '0) begin
              w_state_nxt = ST_CHANGE;
              w_take_chg  = 1'b1;
            end
          end else if (w_key_valid && (r_credit >= CREDIT_W'(w_price))) begin
            w_credit_nxt = CREDIT_W'(w_base - SUM_W'(w_price));
            w_item_nxt   = i_key;
            w_price_nxt  = w_price;
            w_timer_nxt  = '0;
            w_state_nxt  = ST_VEND;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end
      ST_VEND: begin
        w_timer_nxt = r_timer + 1'b1;
        if (i_dispense_ack) begin
          if ((AUTO_CHANGE != 0) && (r_credit != '0)) begin
            w_state_nxt = ST_CHANGE;
            w_take_chg  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          w_fault_nxt  = 1'b1;
          w_credit_nxt = r_credit + CREDIT_W'(r_price);
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (r_credit == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap == '0) begin
          w_take_chg = 1'b1;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Greedy change pulse; credit drops in the same cycle the pulse is shown
    if (w_take_chg) begin
      w_gap_nxt = GAP_W'(RET_GAP - 1);
      if (w_base >= SUM_W'(5)) begin
        w_quarter_nxt = 1'b1;
        w_credit_nxt  = CREDIT_W'(w_base - SUM_W'(5));
      end else if (w_base >= SUM_W'(2)) begin
        w_dime_nxt   = 1'b1;
        w_credit_nxt = CREDIT_W'(w_base - SUM_W'(2));
      end else begin
        w_nickel_nxt = 1'b1;
        w_credit_nxt = CREDIT_W'(w_base - SUM_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_item         <= '0;
      r_price        <= '0;
      r_timer        <= '0;
      r_gap          <= '0;
      r_dispense_req <= 1'b0;
      r_nickel       <= 1'b0;
      r_dime         <= 1'b0;
      r_quarter      <= 1'b0;
      r_reject       <= 1'b0;
      r_sel_err      <= 1'b0;
      r_fault        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_item         <= w_item_nxt;
      r_price        <= w_price_nxt;
      r_timer        <= w_timer_nxt;
      r_gap          <= w_gap_nxt;
      r_dispense_req <= (w_state_nxt == ST_VEND);
      r_nickel       <= w_nickel_nxt;
      r_dime         <= w_dime_nxt;
      r_quarter      <= w_quarter_nxt;
      r_reject       <= w_reject_nxt;
      r_sel_err      <= w_sel_err_nxt;
      r_fault        <= w_fault_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_credit        = r_credit;
  assign o_dispense_req  = r_dispense_req;
  assign o_dispense_item = r_item;
  assign o_ret_nickel    = r_nickel;
  assign o_ret_dime      = r_dime;
  assign o_ret_quarter   = r_quarter;
  assign o_coin_reject   = r_reject;
  assign o_sel_error     = r_sel_err;
  assign o_fault         = r_fault;
  assign o_busy          = r_busy;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Parametrised vending-machine top controller. Accumulates coin credit, validates keypad selections against a per-item price table, and drives a dispense handshake.
- Returns change greedily (quarter > dime > nickel) through paced one-cycle pulses.
- Generalises the single-item controller to N items, configurable credit width, auto/manual change mode, and dispense-ack timeout with refund.
- All money values are in nickel units (1 = 5 cents).

Parameters:
NUM_ITEMS, 8, number of selectable items; valid keys 0..NUM_ITEMS-1 (max 15)
CREDIT_W, 8, credit register width in nickel units
PRICE_W, 6, width of each price entry in nickel units (PRICE_W <= CREDIT_W)
AUTO_CHANGE, 1, 1 = return all remaining credit after each vend; 0 = keep credit for further purchases
RET_GAP, 4, cycles between consecutive change pulses (>=1)
ACK_TIMEOUT, 1000, cycles to wait for dispense_ack before fault and refund

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
coin_valid  in  1  one-cycle strobe, coin detected (pre-synchronised)
coin_type  in  2  0 nickel(1), 1 dime(2), 2 quarter(5), 3 dollar(20)
key  in  4  keypad code; 4'hF = coin return
key_ready  in  1  one-cycle strobe, key valid
item_prices  in  NUM_ITEMS*PRICE_W  flattened price table; item i at [i*PRICE_W +: PRICE_W]
dispense_ack  in  1  dispenser done; sampled only in VEND
credit  out  CREDIT_W  current credit (registered)
dispense_req  out  1  held high in VEND
dispense_item  out  4  item being vended; valid while dispense_req
ret_nickel, ret_dime, ret_quarter  out  1 each  one-cycle change pulses
coin_reject  out  1  one-cycle pulse, inserted coin not accepted (mechanically returned)
sel_error  out  1  one-cycle pulse, invalid key or insufficient credit
fault  out  1  one-cycle pulse, dispense timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, priority over all): state IDLE, credit 0, all outputs 0, timers 0. Reset mid-VEND/CHANGE abandons the operation; credit is lost.
- All outputs are registered; each responds one cycle after the triggering input edge.
- States: IDLE, VEND, CHANGE.
- IDLE coin: if credit + value <= 2^CREDIT_W-1, add value to credit; else credit unchanged and coin_reject pulses.
- IDLE key_ready:
  - key=F: go to CHANGE if credit>0; otherwise no action.
  - key < NUM_ITEMS and credit >= price[key]: credit -= price, latch dispense_item, go to VEND.
  - Otherwise (key >= NUM_ITEMS and !=F, or credit < price): sel_error pulses, stay IDLE.
  - Price 0 is a free vend.
- Simultaneous coin and key in IDLE: the price check uses the pre-coin credit register. Saturation check uses credit + value. Both take effect on the same edge: credit_next = credit - price + value.
- Non-IDLE: every coin_valid produces coin_reject; key_ready is ignored, including F.
- VEND:
  - dispense_req=1 and timer counts up.
  - dispense_ack: dispense_req drops next cycle; go to CHANGE if AUTO_CHANGE and credit>0, else IDLE.
  - Timer reaching ACK_TIMEOUT with no ack: fault pulses, credit += price (refund), go to IDLE. An ack on the timeout cycle wins over the timeout.
- CHANGE:
  - Emits one pulse per RET_GAP cycles. The first pulse is on the first CHANGE cycle.
  - Coin choice: credit>=5 gives quarter (-5), else >=2 gives dime (-2), else nickel (-1). Credit decrements in the same cycle the pulse is high.
  - Return to IDLE on the cycle after credit reaches 0.
  - Dollars are never returned as a single coin; they come back as quarters.
- Credit never wraps. Subtraction only happens when the value is known to be sufficient.
- busy = (state != IDLE).

Test Plan:
- Reset, insert quarter, dime, nickel -> credit 5, 7, 8; no pulses; busy 0.
- price[3]=7, credit 8, key 3 -> credit 1, dispense_req=1 with item 3; ack after 5 cycles -> req drops; AUTO_CHANGE=1 gives one ret_nickel, then IDLE, credit 0.
- credit 4, key 3 (price 7) -> sel_error one cycle, credit stays 4. Key 9 with NUM_ITEMS=8 -> sel_error.
- credit 12, key F, RET_GAP=4 -> ret_quarter, ret_quarter, ret_dime at cycles 0, 4, 8; credit 12→7→2→0; then IDLE.
- CREDIT_W=5, credit 25, insert dollar -> coin_reject, credit 25. Coin during VEND -> coin_reject. Coin and key on the same cycle -> credit = old - price + value.
- ACK_TIMEOUT=10, no ack -> fault at cycle 10, credit restored to pre-vend value, IDLE. Reset asserted mid-CHANGE -> next cycle credit 0, IDLE, no pulses.
